// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: fetch/decode shared widths and the IF/ID entry type.
package if_id_queue_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] npc;
    } if_id_entry_t;
endpackage

// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch-side and decode-side handshakes of the IF/ID queue.
interface if_id_queue_if
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [ILEN-1:0]        in_instr;
    logic [XLEN-1:0]        in_npc;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [ILEN-1:0]        out_instr;
    logic [XLEN-1:0]        out_pc;
    logic [XLEN-1:0]        out_npc;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output in_valid, in_instr, in_npc, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_npc, count
    );

    modport slave (
        input  in_valid, in_instr, in_npc, flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_npc, count
    );
endinterface

// File: rtl/if_id_queue_sync_fifo.sv
// sync_fifo: circular buffer with wrapping pointers; full/empty come from count.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (clr) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr_en) wp <= wp + 1'b1;
            if (rd_en) rp <= rp + 1'b1;
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clr) mem[wp] <= wr_data;
    end

    assign rd_data = mem[rp];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: IF/ID buffer with flush priority, PC reconstruction and zeroed idle outputs.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          reset_n,
    if_id_queue_if.slave q
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] cnt;
    if_id_entry_t  head;
    logic          ready;
    logic          valid;
    logic          push;
    logic          pop;

    // Ready depends only on occupancy, so a full queue never accepts even while popping.
    assign ready = cnt < CW'(DEPTH);
    assign valid = cnt != '0;
    assign push  = q.in_valid && ready && !q.flush;
    assign pop   = valid && q.out_ready && !q.flush;

    sync_fifo #(
        .DEPTH(DEPTH),
        .WIDTH($bits(if_id_entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (q.flush),
        .wr_en   (push),
        .wr_data ({q.in_instr, q.in_npc}),
        .rd_en   (pop),
        .rd_data (head),
        .count   (cnt)
    );

    assign q.in_ready  = ready;
    assign q.out_valid = valid;
    assign q.count     = cnt;
    assign q.out_instr = valid ? head.instr : '0;
    assign q.out_npc   = valid ? head.npc : '0;
    assign q.out_pc    = valid ? head.npc - XLEN'(INSTR_BYTES) : '0;
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: queue-model scoreboard plus directed literal checks for if_id_queue.
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    if_id_entry_t mq[$];
    bit           m_push;
    bit           m_pop;

    if_id_queue_if #(.DEPTH(DEPTH)) bus ();

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an unbounded queue capped at DEPTH, advanced by the handshake rules.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
        end else if (bus.flush) begin
            mq.delete();
        end else begin
            m_pop  = mq.size() != 0 && bus.out_ready;
            m_push = bus.in_valid && mq.size() < DEPTH;
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back('{instr: bus.in_instr, npc: bus.in_npc});
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("count", 64'(bus.count), 64'(mq.size()));
            chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
            chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < DEPTH));
            if (mq.size() != 0) begin
                chk("out_instr", 64'(bus.out_instr), 64'(mq[0].instr));
                chk("out_npc", bus.out_npc, mq[0].npc);
                chk("out_pc", bus.out_pc, mq[0].npc - 64'd4);
            end else begin
                chk("idle_instr", 64'(bus.out_instr), 64'd0);
                chk("idle_npc", bus.out_npc, 64'd0);
                chk("idle_pc", bus.out_pc, 64'd0);
            end
        end
    end

    // Drives inputs for one edge, then returns 1 time unit after that edge.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [63:0] npc,
                       input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.in_npc    = npc;
        bus.out_ready = rdy;
        bus.flush     = fl;
        @(posedge clk);
        #1;
    endtask

    logic [63:0] fill_pc [5] = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10};

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_npc    = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_pc", bus.out_pc, 64'd0);

        cyc(1'b1, 32'h13, 64'h1004, 1'b1, 1'b0);
        chk("sp_valid", 64'(bus.out_valid), 64'd1);
        chk("sp_instr", 64'(bus.out_instr), 64'h13);
        chk("sp_pc", bus.out_pc, 64'h1000);
        chk("sp_npc", bus.out_npc, 64'h1004);
        cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("sp_empty", 64'(bus.out_valid), 64'd0);
        chk("sp_count", 64'(bus.count), 64'd0);

        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 32'h100 + 32'(i), 64'(4 * i), 1'b0, 1'b0);
            if (i == 4) chk("fill_ready", 64'(bus.in_ready), 64'd0);
        end
        chk("fill_count", 64'(bus.count), 64'd4);
        for (int k = 0; k < 5; k++) begin
            chk("drain_pc", bus.out_pc, fill_pc[k]);
            cyc(k < 2, 32'h105, 64'h14, 1'b1, 1'b0);
        end
        chk("drain_count", 64'(bus.count), 64'd0);

        cyc(1'b1, 32'h200, 64'h2000, 1'b0, 1'b0);
        cyc(1'b1, 32'h201, 64'h2004, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) begin
            chk("pp_pc", bus.out_pc, 64'h1FFC + 64'(4 * j));
            cyc(1'b1, 32'h202 + 32'(j), 64'h2008 + 64'(4 * j), 1'b1, 1'b0);
            chk("pp_count", 64'(bus.count), 64'd2);
        end
        repeat (2) cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300 + 32'(i), 64'h3000 + 64'(4 * i), 1'b0, 1'b0);
        chk("pre_flush_count", 64'(bus.count), 64'd3);
        cyc(1'b1, 32'hDEAD, 64'h3FF0, 1'b1, 1'b1);
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) cyc(1'b1, 32'hBEEF, 64'h3FF4, 1'b1, 1'b1);
        chk("flush_hold", 64'(bus.count), 64'd0);
        cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("post_flush_valid", 64'(bus.out_valid), 64'd0);

        cyc(1'b1, 32'h33, 64'h0, 1'b1, 1'b0);
        chk("wrap_pc", bus.out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        cyc(1'b1, 32'h400, 64'h4000, 1'b0, 1'b0);
        cyc(1'b1, 32'h401, 64'h4004, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_count", 64'(bus.count), 64'd0);
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_ready", 64'(bus.in_ready), 64'd1);
        chk("arst_pc", bus.out_pc, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(1'b1, 32'h500, 64'h5008, 1'b1, 1'b0);
        chk("post_rst_pc", bus.out_pc, 64'h5004);
        cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Receiving end of the fetch-to-decode (IF/ID) interface.
- Accepts the fetched instruction word and its next-PC from the fetch stage through a valid/ready handshake.
- Buffers up to DEPTH entries in order and presents them to decode with a second valid/ready handshake.
- Reconstructs the instruction's own PC, and discards all buffered entries when execute redirects the PC.

Parameters:
- DEPTH, 4, number of buffered entries; power of two, at least 2.
- XLEN, 64, PC width.
- ILEN, 32, instruction word width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  fetch presents a valid instruction this cycle.
- in_ready  output  1  queue can accept an entry this cycle.
- in_instr  input  ILEN  fetched instruction word.
- in_npc  input  XLEN  PC+4 of the fetched instruction.
- flush  input  1  execute redirect; discard everything.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode consumes the head this cycle.
- out_instr  output  ILEN  head instruction word.
- out_pc  output  XLEN  head instruction PC.
- out_npc  output  XLEN  head next-PC.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset_n low, asynchronous):
  - read/write pointers = 0, count = 0, out_valid = 0, in_ready = 1.
  - out_instr, out_pc, out_npc = 0.
  - Storage contents are don't-care.
- Push: occurs when in_valid && in_ready && !flush. The entry {in_instr, in_npc} is written at the write pointer, which then increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready && !flush. The read pointer increments modulo DEPTH.
- Handshake rules:
  - in_ready = (count < DEPTH). It is registered-state only and never depends on out_ready in the same cycle (no push-through-when-full).
  - out_valid = (count != 0).
- Latency: an entry pushed at edge N is visible on out_* after edge N; it can be consumed no earlier than the cycle following the push. There is no same-cycle bypass from in_* to out_*.
- Output data:
  - When out_valid = 1: out_instr/out_npc = head entry, and out_pc = out_npc - 4 computed modulo 2^XLEN (npc 0 gives all-ones minus 3).
  - When out_valid = 0: out_instr, out_pc, out_npc are driven to 0.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance. This is legal whenever 0 < count < DEPTH.
- Full (count = DEPTH): in_ready = 0, so in_valid is ignored. A pop in that cycle frees one slot; in_ready rises in the next cycle.
- Empty (count = 0): out_valid = 0 and out_ready is ignored. A push in that cycle makes out_valid = 1 in the next cycle.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from count, not from pointer equality.
- Flush (synchronous, highest priority):
  - At the edge where flush = 1: pointers = 0, count = 0. A concurrent push is dropped; a concurrent pop is not counted.
  - In the following cycle: out_valid = 0, in_ready = 1.
  - flush held high for multiple cycles keeps the queue empty.
- Order: strictly FIFO; no reordering or duplication.
- Reset mid-operation: takes effect immediately regardless of clk; all in-flight entries are lost.
- Inputs are not checked for X when in_valid = 0.

Decomposition:
- Shared package holds:
  - XLEN, ILEN, and INSTR_BYTES = 4 constants.
  - Typedef if_id_entry_t {instr, npc}, used by both the fetch stage and this queue.
  - Keep the package in instructions.sv alongside the existing opcode definitions.
- Natural sub-module: sync_fifo, a generic entry-typed circular buffer with pointers and count.
- if_id_queue wraps sync_fifo with the flush priority, the out_pc subtraction, and zeroing of the outputs when invalid.

Test Plan:
- Reset: assert reset_n = 0 asynchronously mid-cycle -> count = 0, out_valid = 0, in_ready = 1, out_pc = 0 immediately.
- Single pass: push instr 0x00000013 with npc 0x1004, out_ready = 1 -> next cycle out_valid = 1, out_instr = 0x00000013, out_pc = 0x1000, out_npc = 0x1004; then empty.
- Fill and backpressure: out_ready = 0, push 5 entries with npc 0x4, 0x8, 0xC, 0x10, 0x14 -> in_ready = 0 after the 4th push, and the 5th is held. Then out_ready = 1 -> pops yield out_pc = 0x0, 0x4, 0x8, 0xC, 0x10 in order across the pointer wrap.
- Simultaneous push/pop at count = 2 for 10 cycles -> count stays 2 and output order is preserved.
- Flush with in_valid = 1 and count = 3 -> next cycle count = 0, out_valid = 0; the flushed-cycle entry never appears at out_*.
- Wrap arithmetic: push npc = 0x0 -> out_pc = 0xFFFF_FFFF_FFFF_FFFC.
